rs_issue_scheduler: RTL and testbench

//  Per-cycle issue arbiter between the reservation station and the three functional units.

---
 rtl/rs_issue_scheduler.sv | 177 +++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// Issue arbiter between the reservation station and three functional units.
// FU1/FU2 (ALUs) receive single-cycle registered issue strobes; FU3 (mem) is
// driven through a valid/ready handshake held by a two-state FSM. Each FU has
// its own round-robin pointer. rs_clear tells the RS which rows were issued.
module rs_issue_scheduler #(
  parameter  int unsigned RS_ROWS = 16,
  localparam int unsigned IDX_W   = $clog2(RS_ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 issue_en,
  input  logic [RS_ROWS-1:0]   rs_ready,
  input  logic [2*RS_ROWS-1:0] rs_fu,
  output logic                 fu1_valid,
  output logic [IDX_W-1:0]     fu1_row,
  output logic                 fu2_valid,
  output logic [IDX_W-1:0]     fu2_row,
  output logic                 fu3_valid,
  output logic [IDX_W-1:0]     fu3_row,
  input  logic                 fu3_ready,
  output logic [RS_ROWS-1:0]   rs_clear,
  output logic                 bad_fu
);

  typedef enum logic {S_IDLE, S_BUSY} fu3_state_t;

  fu3_state_t         r_state;
  fu3_state_t         w_state_nxt;
  logic               w_fu3_load;

  logic               r_fu1_valid;
  logic               r_fu2_valid;
  logic [IDX_W-1:0]   r_fu1_row;
  logic [IDX_W-1:0]   r_fu2_row;
  logic [IDX_W-1:0]   r_fu3_row;
  logic [IDX_W-1:0]   r_ptr1;
  logic [IDX_W-1:0]   r_ptr2;
  logic [IDX_W-1:0]   r_ptr3;
  logic               r_bad_fu;

  logic [RS_ROWS-1:0] w_clear;
  logic [RS_ROWS-1:0] w_elig;
  logic [RS_ROWS-1:0] w_req1;
  logic [RS_ROWS-1:0] w_req2;
  logic [RS_ROWS-1:0] w_req3;
  logic               w_bad_any;
  logic               w_fu3_open;
  logic               w_fu3_hs;
  logic [IDX_W:0]     w_pick1;
  logic [IDX_W:0]     w_pick2;
  logic [IDX_W:0]     w_pick3;
  logic               w_g1;
  logic               w_g2;
  logic               w_g3;

  // Round-robin pick: {found, index} of the first set request at or after ptr.
  function automatic logic [IDX_W:0] rr_pick(input logic [RS_ROWS-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned off = 0; off < RS_ROWS; off++) begin
      idx = ptr + IDX_W'(off);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  assign w_fu3_hs   = (r_state == S_BUSY) && fu3_ready;
  // FU3 may take a new row when idle, or in the same edge its held row is accepted.
  assign w_fu3_open = (r_state == S_IDLE) || w_fu3_hs;

  // Rows issued in the current cycle; also masks them from re-issue at this edge.
  always_comb begin
    w_clear = '0;
    if (r_fu1_valid) w_clear[r_fu1_row] = 1'b1;
    if (r_fu2_valid) w_clear[r_fu2_row] = 1'b1;
    if (w_fu3_hs)    w_clear[r_fu3_row] = 1'b1;
  end

  // Per-row eligibility, per-FU request vectors and illegal-fu detection.
  always_comb begin
    w_elig    = '0;
    w_req1    = '0;
    w_req2    = '0;
    w_req3    = '0;
    w_bad_any = 1'b0;
    for (int unsigned i = 0; i < RS_ROWS; i++) begin
      w_elig[i] = rs_ready[i] && issue_en && !w_clear[i] && !flush &&
                  !((r_state == S_BUSY) && (r_fu3_row == IDX_W'(i)));
      w_req1[i] = w_elig[i] && (rs_fu[2*i +: 2] == 2'b00);
      w_req2[i] = w_elig[i] && (rs_fu[2*i +: 2] == 2'b01);
      w_req3[i] = w_elig[i] && (rs_fu[2*i +: 2] == 2'b10) && w_fu3_open;
      if (rs_ready[i] && (rs_fu[2*i +: 2] == 2'b11)) w_bad_any = 1'b1;
    end
  end

  assign w_pick1 = rr_pick(w_req1, r_ptr1);
  assign w_pick2 = rr_pick(w_req2, r_ptr2);
  assign w_pick3 = rr_pick(w_req3, r_ptr3);
  assign w_g1    = w_pick1[IDX_W];
  assign w_g2    = w_pick2[IDX_W];
  assign w_g3    = w_pick3[IDX_W];

  // FU3 handshake next-state: load on grant, release on acceptance without a follow-on grant.
  always_comb begin
    w_state_nxt = r_state;
    w_fu3_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_g3) begin
          w_fu3_load  = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (fu3_ready) begin
          if (w_g3) w_fu3_load  = 1'b1;
          else      w_state_nxt = S_IDLE;
        end
      end
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_fu3_load  = 1'b0;
    end
  end

  // State, issue registers and pointers; flush drops valids because it suppresses all grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fu1_valid <= 1'b0;
      r_fu2_valid <= 1'b0;
      r_fu1_row   <= '0;
      r_fu2_row   <= '0;
      r_fu3_row   <= '0;
      r_ptr1      <= '0;
      r_ptr2      <= '0;
      r_ptr3      <= '0;
      r_bad_fu    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fu1_valid <= w_g1;
      r_fu2_valid <= w_g2;
      if (w_g1) begin
        r_fu1_row <= w_pick1[IDX_W-1:0];
        r_ptr1    <= w_pick1[IDX_W-1:0] + IDX_W'(1);
      end
      if (w_g2) begin
        r_fu2_row <= w_pick2[IDX_W-1:0];
        r_ptr2    <= w_pick2[IDX_W-1:0] + IDX_W'(1);
      end
      if (w_fu3_load) begin
        r_fu3_row <= w_pick3[IDX_W-1:0];
        r_ptr3    <= w_pick3[IDX_W-1:0] + IDX_W'(1);
      end
      if (w_bad_any) r_bad_fu <= 1'b1;
    end
  end

  assign fu1_valid = r_fu1_valid;
  assign fu1_row   = r_fu1_row;
  assign fu2_valid = r_fu2_valid;
  assign fu2_row   = r_fu2_row;
  assign fu3_valid = (r_state == S_BUSY);
  assign fu3_row   = r_fu3_row;
  assign rs_clear  = w_clear;
  assign bad_fu    = r_bad_fu;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler. A small RS model frees rows one edge
// after rs_clear; expected issue rows are queued per FU and compared as issued.
module tb_rs_issue_scheduler;
  localparam int unsigned ROWS = 16;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              flush     = 1'b0;
  logic              issue_en  = 1'b0;
  logic              fu3_ready = 1'b0;
  logic [ROWS-1:0]   rs_ready  = '0;
  logic [2*ROWS-1:0] rs_fu     = '0;
  logic [ROWS-1:0]   in_use    = '0;
  logic              fu1_valid, fu2_valid, fu3_valid, bad_fu;
  logic [3:0]        fu1_row, fu2_row, fu3_row;
  logic [ROWS-1:0]   rs_clear;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [3:0] q3[$];

  always #5 clk = ~clk;

  rs_issue_scheduler #(.RS_ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_en(issue_en),
    .rs_ready(rs_ready), .rs_fu(rs_fu),
    .fu1_valid(fu1_valid), .fu1_row(fu1_row),
    .fu2_valid(fu2_valid), .fu2_row(fu2_row),
    .fu3_valid(fu3_valid), .fu3_row(fu3_row), .fu3_ready(fu3_ready),
    .rs_clear(rs_clear), .bad_fu(bad_fu)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: capture rs_clear before the edge, then the RS frees those rows.
  task automatic tick();
    logic [ROWS-1:0] clr;
    @(negedge clk);
    clr = rs_clear;
    @(posedge clk);
    #1;
    in_use   = in_use & ~clr;
    rs_ready = in_use;
  endtask

  task automatic set_fu(input int r, input logic [1:0] f);
    rs_fu[2*r +: 2] = f;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; issue_en = 1'b1; fu3_ready = 1'b0;
    rs_fu = '0; in_use = '0; rs_ready = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Scoreboard side: every issue (FU1/FU2 strobe, FU3 handshake) pops its FU queue.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset) begin
      if (fu1_valid) begin
        checks++;
        assert (q1.size() > 0) else begin errors++; $error("FAIL fu1_unexpected: got row %0d expected no issue", fu1_row); end
        if (q1.size() > 0) begin
          e = q1.pop_front(); checks++;
          assert (fu1_row === e) else begin errors++; $error("FAIL fu1_order: got %0d expected %0d", fu1_row, e); end
        end
      end
      if (fu2_valid) begin
        checks++;
        assert (q2.size() > 0) else begin errors++; $error("FAIL fu2_unexpected: got row %0d expected no issue", fu2_row); end
        if (q2.size() > 0) begin
          e = q2.pop_front(); checks++;
          assert (fu2_row === e) else begin errors++; $error("FAIL fu2_order: got %0d expected %0d", fu2_row, e); end
        end
      end
      if (fu3_valid && fu3_ready) begin
        checks++;
        assert (q3.size() > 0) else begin errors++; $error("FAIL fu3_unexpected: got row %0d expected no issue", fu3_row); end
        if (q3.size() > 0) begin
          e = q3.pop_front(); checks++;
          assert (fu3_row === e) else begin errors++; $error("FAIL fu3_order: got %0d expected %0d", fu3_row, e); end
        end
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_fu1_valid", fu1_valid, 0);
    chk("rst_fu2_valid", fu2_valid, 0);
    chk("rst_fu3_valid", fu3_valid, 0);
    chk("rst_rows", {fu1_row, fu2_row, fu3_row}, 0);
    chk("rst_clear", rs_clear, 0);
    chk("rst_bad_fu", bad_fu, 0);

    // 1) two FU1 rows, no re-issue of row 0
    set_fu(0, 2'b00); set_fu(1, 2'b00);
    in_use = 16'h0003; rs_ready = in_use;
    q1.push_back(4'd0); q1.push_back(4'd1);
    tick(); chk("t1_valid_c1", fu1_valid, 1); chk("t1_row_c1", fu1_row, 0); chk("t1_clear_c1", rs_clear, 16'h0001);
    tick(); chk("t1_valid_c2", fu1_valid, 1); chk("t1_row_c2", fu1_row, 1); chk("t1_clear_c2", rs_clear, 16'h0002);
    tick(); chk("t1_idle", fu1_valid, 0); chk("t1_clear_idle", rs_clear, 0);

    // 2) FU2 round robin 0,5,9 then 12,2 across the wrap
    set_fu(0, 2'b01); set_fu(5, 2'b01); set_fu(9, 2'b01);
    in_use = in_use | 16'h0221; rs_ready = in_use;
    q2.push_back(4'd0); q2.push_back(4'd5); q2.push_back(4'd9);
    tick(); chk("t2_row0", fu2_row, 0);
    tick(); chk("t2_row5", fu2_row, 5);
    tick(); chk("t2_row9", fu2_row, 9); chk("t2_clear9", rs_clear, 16'h0200);
    tick(); chk("t2_idle", fu2_valid, 0);
    set_fu(12, 2'b01); set_fu(2, 2'b01);
    in_use = in_use | 16'h1004; rs_ready = in_use;
    q2.push_back(4'd12); q2.push_back(4'd2);
    tick(); chk("t2_row12", fu2_row, 12);
    tick(); chk("t2_wrap_row2", fu2_row, 2);
    tick(); chk("t2_idle2", fu2_valid, 0); chk("t2_no_fu1", fu1_valid, 0);

    // 3) FU3 request held while fu3_ready=0
    set_fu(3, 2'b10); fu3_ready = 1'b0;
    in_use = in_use | 16'h0008; rs_ready = in_use;
    q3.push_back(4'd3);
    tick(); chk("t3_valid", fu3_valid, 1); chk("t3_row", fu3_row, 3); chk("t3_clear", rs_clear, 0);
    for (int c = 0; c < 3; c++) begin
      tick(); chk("t3_hold_valid", fu3_valid, 1); chk("t3_hold_row", fu3_row, 3); chk("t3_hold_clear", rs_clear, 0);
    end
    fu3_ready = 1'b1; #1;
    chk("t3_accept_clear", rs_clear, 16'h0008);
    tick(); chk("t3_idle", fu3_valid, 0); chk("t3_idle_clear", rs_clear, 0);

    // 4) back-to-back FU3 rows 2,4 with fu3_ready high
    do_reset();
    set_fu(2, 2'b10); set_fu(4, 2'b10); fu3_ready = 1'b1;
    in_use = 16'h0014; rs_ready = in_use;
    q3.push_back(4'd2); q3.push_back(4'd4);
    tick(); chk("t4_row2", fu3_row, 2); chk("t4_valid2", fu3_valid, 1); chk("t4_clear2", rs_clear, 16'h0004);
    tick(); chk("t4_row4", fu3_row, 4); chk("t4_valid4", fu3_valid, 1); chk("t4_clear4", rs_clear, 16'h0010);
    tick(); chk("t4_idle", fu3_valid, 0); chk("t4_idle_clear", rs_clear, 0);

    // 5) illegal fu code: never issued, sticky through flush, cleared by reset
    set_fu(7, 2'b11); in_use = 16'h0080; rs_ready = in_use;
    chk("t5_bad_before", bad_fu, 0);
    tick(); chk("t5_bad_set", bad_fu, 1);
    chk("t5_no_valid", {fu1_valid, fu2_valid, fu3_valid}, 0);
    tick(); chk("t5_no_valid2", {fu1_valid, fu2_valid, fu3_valid}, 0);
    in_use = '0; rs_ready = in_use; flush = 1'b1;
    tick(); flush = 1'b0;
    chk("t5_bad_after_flush", bad_fu, 1);
    do_reset();
    chk("t5_bad_after_reset", bad_fu, 0);

    // 6) flush with FU3 busy on row 6 and FU1 active; pointers must survive
    set_fu(6, 2'b10); set_fu(1, 2'b00); fu3_ready = 1'b0;
    in_use = 16'h0042; rs_ready = in_use;
    q1.push_back(4'd1);
    tick(); chk("t6_fu3_busy", fu3_valid, 1); chk("t6_fu3_row", fu3_row, 6);
    chk("t6_fu1_row", fu1_row, 1); chk("t6_clear", rs_clear, 16'h0002);
    set_fu(0, 2'b00); set_fu(5, 2'b00); set_fu(4, 2'b10); set_fu(8, 2'b10);
    in_use = in_use | 16'h0131; rs_ready = in_use; flush = 1'b1;
    tick(); flush = 1'b0;
    chk("t6_flushed", {fu1_valid, fu2_valid, fu3_valid}, 0); chk("t6_flush_clear", rs_clear, 0);
    in_use = in_use & ~16'h0040; rs_ready = in_use; fu3_ready = 1'b1;
    q1.push_back(4'd5); q1.push_back(4'd0); q3.push_back(4'd8); q3.push_back(4'd4);
    tick(); chk("t6_ptr1_kept", fu1_row, 5); chk("t6_ptr3_kept", fu3_row, 8);
    tick(); chk("t6_fu1_next", fu1_row, 0); chk("t6_fu3_next", fu3_row, 4);
    tick(); chk("t6_idle", {fu1_valid, fu2_valid, fu3_valid}, 0);

    // 7) issue_en low blocks new grants
    issue_en = 1'b0; set_fu(10, 2'b00); in_use = 16'h0400; rs_ready = in_use;
    tick(); chk("t7_blocked1", fu1_valid, 0);
    tick(); chk("t7_blocked2", fu1_valid, 0);
    issue_en = 1'b1; q1.push_back(4'd10);
    tick(); chk("t7_valid", fu1_valid, 1); chk("t7_row", fu1_row, 10);
    tick(); chk("t7_idle", fu1_valid, 0);

    tick();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
